cache_arbiter: RTL and testbench
================================

// Module: cache_arbiter
// PURPOSE
//  Shares the single physical-memory port between the I-cache and D-cache miss paths of the pipelined LC-3b.
//  Each requester issues line-sized read/write transactions. The arbiter picks one, steers it to pmem, and
//  returns pmem_resp to the winner only. It sits between the two caches and physical memory.
//  Pipeline stall logic (imem_resp/dmem_resp) sees it only through the caches.
// PARAMETERS
//  ADDR_WIDTH  16   byte address width (lc3b_word)
//  LINE_WIDTH  128  cache line / pmem data width in bits
// PORTS
//  clk           in   1           rising-edge clock
//  reset         in   1           asynchronous, active-low reset (0 = reset asserted)
//  i_read        in   1           I-cache line read request (level, held until i_resp)
//  i_address     in   ADDR_WIDTH  I-cache line address
//  i_rdata       out  LINE_WIDTH  read data to I-cache; valid only while i_resp=1
//  i_resp        out  1           I-cache transaction done (1-cycle pulse)
//  d_read        in   1           D-cache line read request (level, held until d_resp)
//  d_write       in   1           D-cache line writeback request (level, held until d_resp)
//  d_address     in   ADDR_WIDTH  D-cache line address
//  d_wdata       in   LINE_WIDTH  D-cache writeback data
//  d_rdata       out  LINE_WIDTH  read data to D-cache; valid only while d_resp=1
//  d_resp        out  1           D-cache transaction done (1-cycle pulse)
//  pmem_read     out  1           physical memory read strobe
//  pmem_write    out  1           physical memory write strobe
//  pmem_address  out  ADDR_WIDTH  physical memory address
//  pmem_wdata    out  LINE_WIDTH  physical memory write data
//  pmem_rdata    in   LINE_WIDTH  physical memory read data
//  pmem_resp     in   1           physical memory done (1-cycle pulse)
// BEHAVIOUR
//  State machine and reset
//  - States: IDLE, SERVE_I, SERVE_D. Plus 1-bit last_grant register (0=I, 1=D).
//  - reset=0: state=IDLE and last_grant=I, asynchronously. All outputs except rdata go 0 immediately.
//    This applies even mid-transaction: the transaction is abandoned. A pmem_resp arriving later in IDLE is ignored.
//  - i_rdata = d_rdata = pmem_rdata at all times (combinational); consumers qualify with *_resp.
//  Arbitration (IDLE, registered at clock edge)
//  - d_req = d_read|d_write; i_req = i_read.
//  - Only d_req: go to SERVE_D. Only i_req: go to SERVE_I. Neither: stay in IDLE.
//  - Both: grant the requester that is not last_grant. After reset, D wins the first tie.
//  - last_grant updates to the winner on entering SERVE_x.
//  Serving
//  - IDLE drives pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0.
//  - SERVE_I: pmem_read=i_read, pmem_write=0, pmem_address=i_address, pmem_wdata=0.
//  - SERVE_D: pmem_write=d_write, pmem_read=d_read&~d_write, pmem_address=d_address, pmem_wdata=d_wdata.
//    d_read and d_write together is illegal; write wins.
//  - pmem signals are combinational from the granted requester's inputs and the current state.
//  - i_resp = pmem_resp & (state==SERVE_I). d_resp = pmem_resp & (state==SERVE_D).
//    The non-granted requester never sees a resp.
//  - pmem_resp in SERVE_x: next state=IDLE. One mandatory IDLE cycle follows, so the requester can drop its request.
//  - Granted requester drops all request lines before pmem_resp (abort): next state=IDLE, no resp.
//  - The non-granted requester's inputs may change freely; it stays pending.
//  Latency
//  - Request rises in IDLE at cycle 0 -> pmem strobe asserted in cycle 1.
//  - pmem_resp in cycle N -> *_resp in cycle N (same cycle) -> IDLE in cycle N+1 -> next grant's strobe in N+2.
//  - Back-to-back contention alternates I/D. Neither requester waits more than one other transaction.
// TESTING
//  - Reset, then i_read=1, addr 0x1230 -> pmem_read=1, pmem_address=0x1230 next cycle.
//    pmem_resp with rdata=0xA5..A5 -> i_resp=1 same cycle, i_rdata=0xA5..A5, d_resp=0.
//  - Reset, then i_read and d_write rise together -> SERVE_D first (pmem_write=1, wdata=d_wdata).
//    After d_resp + 1 IDLE cycle -> SERVE_I (pmem_read=1, addr=i_address).
//  - Both requesters held continuously for 6 transactions -> grant order D,I,D,I,D,I.
//    Every pmem strobe is separated by >=1 IDLE cycle.
//  - d_read=d_write=1, addr 0x0040 -> pmem_write=1, pmem_read=0. d_resp on pmem_resp.
//  - reset=0 asynchronously mid SERVE_D while pmem_write=1 -> pmem_write=0 before the next clk edge.
//    pmem_resp after release in IDLE -> no i_resp or d_resp.
//  - SERVE_I, then i_read dropped before pmem_resp -> IDLE next cycle, i_resp never asserted.
//    A pending d_read is granted afterwards.

Source files
------------

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache miss paths.
// Alternates grants on contention so neither cache waits more than one transaction.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  // state   | meaning
  // IDLE    | no owner; arbitrate, pmem outputs held at 0
  // SERVE_I | I-cache owns pmem until pmem_resp or abort
  // SERVE_D | D-cache owns pmem until pmem_resp or abort
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t state, state_next;
  logic   last_grant, last_grant_next;   // 0 = I, 1 = D
  logic   i_req, d_req;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    pmem_address    = '0;
    pmem_wdata      = '0;
    i_resp          = 1'b0;
    d_resp          = 1'b0;
    unique case (state)
      IDLE: begin
        // a tie goes to whoever did not win last time
        if (d_req && (!i_req || !last_grant)) begin
          state_next      = SERVE_D;
          last_grant_next = 1'b1;
        end else if (i_req) begin
          state_next      = SERVE_I;
          last_grant_next = 1'b0;
        end
      end
      SERVE_I: begin
        pmem_read    = i_read;
        pmem_address = i_address;
        i_resp       = pmem_resp;
        if (pmem_resp || !i_req) state_next = IDLE;
      end
      SERVE_D: begin
        pmem_write   = d_write;
        pmem_read    = d_read & ~d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
        if (pmem_resp || !d_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level owner/fairness model.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_read, d_read, d_write, pmem_resp;
  logic [15:0]  i_address, d_address;
  logic [127:0] d_wdata, pmem_rdata;
  logic [127:0] i_rdata, d_rdata, pmem_wdata;
  logic         i_resp, d_resp, pmem_read, pmem_write;
  logic [15:0]  pmem_address;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int checks = 0;
  int errors = 0;

  // model: who currently owns pmem (0 none, 1 I-cache, 2 D-cache) and who won last
  int  owner = 0;
  bit  last_d = 1'b0;
  bit  exp_iresp_prev = 1'b0, exp_dresp_prev = 1'b0;
  bit  prev_strobe = 1'b0, prev_dut_resp = 1'b0;
  logic [15:0] grant_seen[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // called at a negedge with inputs already driven; returns at the next negedge
  task automatic cycle();
    logic er, ew, eir, edr, strobe;
    logic [15:0]  ea;
    logic [127:0] ewd;
    bit ireq, dreq;
    #1;
    er = 0; ew = 0; eir = 0; edr = 0; ea = '0; ewd = '0;
    if (reset && owner == 1) begin
      er = i_read; ea = i_address; eir = pmem_resp;
    end else if (reset && owner == 2) begin
      ew = d_write; er = d_read & ~d_write; ea = d_address; ewd = d_wdata; edr = pmem_resp;
    end
    check("pmem_read", pmem_read, er);
    check("pmem_write", pmem_write, ew);
    check("pmem_address", pmem_address, ea);
    check("pmem_wdata", pmem_wdata, ewd);
    check("i_resp", i_resp, eir);
    check("d_resp", d_resp, edr);
    check("i_rdata", i_rdata, pmem_rdata);
    check("d_rdata", d_rdata, pmem_rdata);
    strobe = pmem_read | pmem_write;
    if (prev_dut_resp) check("idle_gap", strobe, 1'b0);
    if (strobe && !prev_strobe) grant_seen.push_back(pmem_address);
    prev_strobe    = strobe & reset;
    prev_dut_resp  = (i_resp | d_resp) & reset;
    exp_iresp_prev = eir;
    exp_dresp_prev = edr;
    @(posedge clk);
    ireq = i_read;
    dreq = d_read | d_write;
    if (!reset) begin
      owner = 0; last_d = 1'b0;
    end else if (owner != 0) begin
      if (pmem_resp || (owner == 1 ? !ireq : !dreq)) owner = 0;
    end else begin
      if (ireq && dreq) owner = last_d ? 1 : 2;
      else if (dreq)    owner = 2;
      else if (ireq)    owner = 1;
      if (owner != 0) last_d = (owner == 2);
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
    reset = 0;
    cycle();
    cycle();
    reset = 1;
  endtask

  initial begin
    int hold;
    reset = 0;
    i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
    @(negedge clk);

    // single I-cache read
    apply_reset();
    i_read = 1; i_address = 16'h1230;
    cycle();
    #1 check("t1_read", pmem_read, 1'b1);
    check("t1_addr", pmem_address, 16'h1230);
    pmem_resp = 1; pmem_rdata = {16{8'hA5}};
    #1 check("t1_iresp", i_resp, 1'b1);
    check("t1_irdata", i_rdata, {16{8'hA5}});
    check("t1_dresp", d_resp, 1'b0);
    cycle();
    pmem_resp = 0; i_read = 0;
    cycle();

    // simultaneous request after reset: D first, then I
    apply_reset();
    i_read = 1; i_address = 16'h0AAA;
    d_write = 1; d_address = 16'h0BBB; d_wdata = rand_line();
    cycle();
    #1 check("t2_d_write", pmem_write, 1'b1);
    check("t2_wdata", pmem_wdata, d_wdata);
    pmem_resp = 1;
    cycle();
    pmem_resp = 0; d_write = 0;
    cycle();
    #1 check("t2_i_read", pmem_read, 1'b1);
    check("t2_i_addr", pmem_address, 16'h0AAA);
    pmem_resp = 1;
    cycle();
    pmem_resp = 0; i_read = 0;
    cycle();

    // both held continuously: alternation D,I,D,I,D,I
    apply_reset();
    grant_seen.delete();
    i_read = 1; i_address = 16'h1111;
    d_read = 1; d_address = 16'h2222;
    hold = 0;
    for (int c = 0; c < 200 && grant_seen.size() < 6; c++) begin
      if (owner != 0) hold++; else hold = 0;
      pmem_resp = (hold >= 2);
      cycle();
    end
    i_read = 0; d_read = 0; pmem_resp = 0;
    cycle();
    cycle();
    check("t3_grants", grant_seen.size(), 6);
    for (int k = 0; k < grant_seen.size() && k < 6; k++)
      check($sformatf("t3_order%0d", k), grant_seen[k], (k % 2 == 0) ? 16'h2222 : 16'h1111);

    // illegal read+write: write wins
    apply_reset();
    d_read = 1; d_write = 1; d_address = 16'h0040; d_wdata = rand_line();
    cycle();
    #1 check("t4_write", pmem_write, 1'b1);
    check("t4_read", pmem_read, 1'b0);
    pmem_resp = 1;
    #1 check("t4_dresp", d_resp, 1'b1);
    cycle();
    pmem_resp = 0; d_read = 0; d_write = 0;
    cycle();

    // asynchronous reset mid SERVE_D
    apply_reset();
    d_write = 1; d_address = 16'h0400; d_wdata = rand_line();
    cycle();
    #1 check("t5_mid_write", pmem_write, 1'b1);
    #1 reset = 0;
    #1 check("t5_async_write", pmem_write, 1'b0);
    check("t5_async_addr", pmem_address, 16'h0000);
    owner = 0; last_d = 1'b0; prev_strobe = 0; prev_dut_resp = 0;
    @(negedge clk);
    d_write = 0;
    cycle();
    reset = 1; pmem_resp = 1;
    cycle();
    pmem_resp = 0;
    cycle();

    // I aborts, pending D granted afterwards
    apply_reset();
    i_read = 1; i_address = 16'h3000;
    cycle();
    d_read = 1; d_address = 16'h5000;
    cycle();
    i_read = 0;
    cycle();
    pmem_resp = 1;
    #1 check("t6_no_iresp", i_resp, 1'b0);
    cycle();
    pmem_resp = 0;
    #1 check("t6_d_granted", pmem_read, 1'b1);
    check("t6_d_addr", pmem_address, 16'h5000);
    pmem_resp = 1;
    cycle();
    pmem_resp = 0; d_read = 0;
    cycle();

    // randomized traffic
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if (i_read) begin
        if (exp_iresp_prev) i_read = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 29) == 0) i_read = 0;
        else if (owner != 1 && $urandom_range(0, 7) == 0) i_address = 16'($urandom);
      end else if ($urandom_range(0, 2) == 0) begin
        i_read = 1; i_address = 16'($urandom);
      end
      if (d_read || d_write) begin
        if (exp_dresp_prev ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 29) == 0)) begin
          d_read = 0; d_write = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, 9);
        d_read  = (k < 5) || (k == 9);
        d_write = (k >= 5);
        d_address = 16'($urandom);
        d_wdata   = rand_line();
      end
      pmem_resp  = (owner != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      pmem_rdata = rand_line();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
